// File: rtl/led7_seg_if.sv
// =============================================================================
// Module      : led7_seg_if
// Description : Display bus for led7_seg: value in, active-low segment and
//               digit-select lines out. Per-digit dp inputs exist only when
//               LED7SEG_DP_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface led7_seg_if;
    logic [15:0] data;
    logic [7:0]  seg;
    logic [3:0]  segsel;
`ifdef LED7SEG_DP_EN
    logic [3:0]  dp;
`endif

`ifdef LED7SEG_DP_EN
    modport master (output data, output dp, input seg, input segsel);
    modport slave  (input data, input dp, output seg, output segsel);
`else
    modport master (output data, input seg, input segsel);
    modport slave  (input data, output seg, output segsel);
`endif
endinterface

`default_nettype wire

// File: rtl/led7_seg.sv
// =============================================================================
// Module      : led7_seg
// Description : Time-multiplexed 4-digit common-anode hex display driver.
//               Optional per-digit decimal points via macro LED7SEG_DP_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module led7_seg #(
    parameter int DIV_BITS = 16
) (
    input  wire logic  clk,
    input  wire logic  reset,
    led7_seg_if.slave  bus
);

    logic [DIV_BITS-1:0] r_cnt;
    logic [1:0]          r_idx;
    logic [7:0]          r_seg;
    logic [3:0]          r_segsel;

    logic [3:0]          w_nib;
    logic [6:0]          w_pat;
    logic                w_dp_n;

    always_comb begin
        w_nib = bus.data[3:0];
        case (r_idx)
            2'd0:    w_nib = bus.data[3:0];
            2'd1:    w_nib = bus.data[7:4];
            2'd2:    w_nib = bus.data[11:8];
            default: w_nib = bus.data[15:12];
        endcase
    end

    // Active-low g..a patterns, bit 0 = segment a.
    always_comb begin
        w_pat = 7'h7F;
        case (w_nib)
            4'h0: w_pat = 7'h40;
            4'h1: w_pat = 7'h79;
            4'h2: w_pat = 7'h24;
            4'h3: w_pat = 7'h30;
            4'h4: w_pat = 7'h19;
            4'h5: w_pat = 7'h12;
            4'h6: w_pat = 7'h02;
            4'h7: w_pat = 7'h78;
            4'h8: w_pat = 7'h00;
            4'h9: w_pat = 7'h10;
            4'hA: w_pat = 7'h08;
            4'hB: w_pat = 7'h03;
            4'hC: w_pat = 7'h46;
            4'hD: w_pat = 7'h21;
            4'hE: w_pat = 7'h06;
            default: w_pat = 7'h0E;
        endcase
    end

`ifdef LED7SEG_DP_EN
    assign w_dp_n = ~bus.dp[r_idx];
`else
    assign w_dp_n = 1'b1;
`endif

    // Outputs use the pre-edge index, so they lag the index by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_seg    <= 8'hFF;
            r_segsel <= 4'hF;
        end else begin
            r_cnt    <= r_cnt + DIV_BITS'(1);
            if (&r_cnt) begin
                r_idx <= r_idx + 2'd1;
            end
            r_segsel <= ~(4'b0001 << r_idx);
            r_seg    <= {w_dp_n, w_pat};
        end
    end

    assign bus.seg    = r_seg;
    assign bus.segsel = r_segsel;

endmodule

`default_nettype wire

// File: tb/tb_led7_seg.sv
// =============================================================================
// Module      : tb_led7_seg
// Description : Directed self-checking bench for led7_seg at DIV_BITS 1, 2, 3.
//               Honours LED7SEG_DP_EN when defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_led7_seg;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    led7_seg_if if1 ();
    led7_seg_if if2 ();
    led7_seg_if if3 ();

    led7_seg #(.DIV_BITS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    led7_seg #(.DIV_BITS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
    led7_seg #(.DIV_BITS(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] c_tab [16];
    logic [3:0] c_sel [4];
    logic [7:0] c_s1234 [4];

    initial begin
        c_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        c_sel   = '{4'hE, 4'hD, 4'hB, 4'h7};
        c_s1234 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        if1.data = 16'h0000;
        if2.data = 16'h1234;
        if3.data = 16'h0000;
`ifdef LED7SEG_DP_EN
        if1.dp = 4'h0;
        if2.dp = 4'h0;
        if3.dp = 4'h0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("reset_seg", if2.seg, 8'hFF);
        check("reset_segsel", {4'h0, if2.segsel}, 8'h0F);
        reset = 1'b0;

        // Scan timing: 4 clocks per digit, order 0,1,2,3 then back to 0.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("scan_segsel", {4'h0, if2.segsel}, {4'h0, c_sel[((k - 1) / 4) % 4]});
            check("scan_seg", if2.seg, c_s1234[((k - 1) / 4) % 4]);
        end

        // Asynchronous reset mid-scan, then held.
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_seg", if2.seg, 8'hFF);
        check("async_rst_segsel", {4'h0, if2.segsel}, 8'h0F);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("held_rst_seg", if2.seg, 8'hFF);
            check("held_rst_segsel", {4'h0, if2.segsel}, 8'h0F);
        end

        // Live update on the current digit.
        if2.data = 16'h00A0;
        reset = 1'b0;
        @(negedge clk);
        check("live_before_seg", if2.seg, 8'hC0);
        check("live_before_segsel", {4'h0, if2.segsel}, 8'h0E);
        if2.data = 16'h00AF;
        @(negedge clk);
        check("live_after_seg", if2.seg, 8'h8E);
        check("live_after_segsel", {4'h0, if2.segsel}, 8'h0E);

        // Full decode sweep: every digit carries the same nibble.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if1.data = 16'(k * 16'h1111);
            @(negedge clk);
            check("decode_seg", if1.seg, c_tab[k]);
            check("decode_onehot", 8'($countones(~if1.segsel)), 8'd1);
        end

        // Wrap and one-hot over three full scans at 8 clocks per digit.
        do_reset();
        for (int k = 1; k <= 96; k++) begin
            @(negedge clk);
            check("wrap_segsel", {4'h0, if3.segsel}, {4'h0, c_sel[((k - 1) / 8) % 4]});
            check("wrap_onehot", 8'($countones(~if3.segsel)), 8'd1);
        end

`ifdef LED7SEG_DP_EN
        if2.data = 16'h8888;
        if2.dp   = 4'b0100;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("dp_seg", if2.seg, (((k - 1) / 4) % 4 == 2) ? 8'h00 : 8'h80);
        end
`else
        if2.data = 16'h8888;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("dp_off_seg", if2.seg, 8'h80);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
